// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer: FSM state encoding,
// note periods for a 50 MHz clock and note durations in tempo units.
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_PLAY
   } state_t;

   localparam int unsigned CLK_HZ = 50_000_000;

   // Rounded clock cycles per tone period for a frequency given in 1/100 Hz.
   function automatic int unsigned note_period(input int unsigned centi_hz);
      return 32'((longint'(CLK_HZ) * 100 + centi_hz / 2) / centi_hz);
   endfunction

   // Note periods (clock cycles per full tone period); SP is a rest.
   localparam int unsigned B4  = note_period(49388);
   localparam int unsigned C5S = note_period(55437);
   localparam int unsigned D5S = note_period(62225);
   localparam int unsigned E5  = note_period(65926);
   localparam int unsigned F5S = note_period(73999);
   localparam int unsigned G5S = note_period(83061);
   localparam int unsigned A5S = note_period(93233);
   localparam int unsigned B5  = note_period(98777);
   localparam int unsigned SP  = 1;

   // Durations in tempo units (one unit = 1/8 s at the default tempo).
   localparam int unsigned QUARTER = 2;
   localparam int unsigned HALF    = 4;
   localparam int unsigned ONE     = 8;
   localparam int unsigned TWO     = 16;
   localparam int unsigned FOUR    = 32;

endpackage

// File: rtl/music_sequencer_tone_gen.sv
// Square-wave tone generator: toggles its output every note/2 enabled cycles.
// Periods below 2 are rests and keep the output low; odd periods truncate.
module tone_gen #(
   parameter int unsigned NOTE_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clear,
   input  logic [NOTE_W-1:0] note,
   output logic              tone
);

   localparam int unsigned HALF_W = NOTE_W - 1;

   logic [HALF_W-1:0] half;
   logic [HALF_W-1:0] half_cnt;
   logic              rest;

   assign half = note[NOTE_W-1:1];
   assign rest = (note < NOTE_W'(2));

   // Half-period counter and output toggle; frozen whenever en is low.
   // NOTE: registers are written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         half_cnt <= '0;
         tone     <= 1'b0;
      end else if (en) begin
         if (rest) begin
            half_cnt <= '0;
            tone     <= 1'b0;
         end else if (half_cnt == half - HALF_W'(1)) begin
            half_cnt <= '0;
            tone     <= ~tone;
         end else begin
            half_cnt <= half_cnt + HALF_W'(1);
         end
      end
   end

endmodule

// File: rtl/music_sequencer.sv
// Music sequencer: walks an external sheet ROM, times each entry in tempo
// units and drives a square-wave speaker output.
// Optional articulation gap: define MUSIC_SEQ_ARTIC_GAP_EN to silence the last
// GAP_CYCLES cycles of every entry without changing entry timing.
module music_sequencer
   import music_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned NOTE_W      = 20,
   parameter int unsigned DUR_W       = 5,
   parameter int unsigned UNIT_CYCLES = 6250000,
   parameter int unsigned GAP_CYCLES  = 500000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] addr,
   input  logic [NOTE_W-1:0] sheet_note,
   input  logic [DUR_W-1:0]  sheet_dur,
   input  logic              sheet_done,
   output logic              tone,
   output logic              busy,
   output logic              song_done
);

   localparam int unsigned UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
   localparam int unsigned REM_W = DUR_W + UNIT_W + 1;
`ifdef MUSIC_SEQ_ARTIC_GAP_EN
   localparam logic GAP_EN = 1'b1;
`else
   localparam logic GAP_EN = 1'b0;
`endif

   state_t            state, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic              song_done_d;
   logic              load;
   logic              entry_end;
   logic              entry_last;

   logic [NOTE_W-1:0] note_q;
   logic [DUR_W-1:0]  units_left;
   logic              done_q;
   logic [UNIT_W-1:0] unit_cnt;
   logic              playing;
   logic              unit_wrap;
   logic              tone_raw;
   logic              gap;
   logic [REM_W-1:0]  cycles_left;

   assign playing   = (state == ST_PLAY) && !pause;
   assign unit_wrap = playing && (unit_cnt == UNIT_LAST);
   assign busy      = (state != ST_IDLE);

   // Cycles remaining in the current entry, including this one.
   assign cycles_left = REM_W'(units_left) * REM_W'(UNIT_CYCLES) - REM_W'(unit_cnt);
   assign gap         = GAP_EN && (cycles_left <= REM_W'(GAP_CYCLES));
   assign tone        = tone_raw && playing && !gap;

   // Next-state, next-address and end-of-entry decisions.
   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state;
      addr_d      = addr;
      song_done_d = 1'b0;
      load        = 1'b0;
      entry_end   = 1'b0;
      entry_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               addr_d  = '0;
            end
         end
         ST_FETCH: begin
            load    = 1'b1;
            state_d = ST_PLAY;
            if (sheet_dur == '0) begin
               entry_end  = 1'b1;
               entry_last = sheet_done;
            end
         end
         ST_PLAY: begin
            if (unit_wrap && (units_left == DUR_W'(1))) begin
               entry_end  = 1'b1;
               entry_last = done_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (entry_end) begin
         if (entry_last && loop_en) begin
            state_d = ST_FETCH;
            addr_d  = '0;
         end else if (entry_last) begin
            state_d     = ST_IDLE;
            addr_d      = '0;
            song_done_d = 1'b1;
         end else begin
            state_d = ST_FETCH;
            addr_d  = addr + ADDR_W'(1);
         end
      end

      if (stop) begin
         state_d     = ST_IDLE;
         addr_d      = '0;
         song_done_d = 1'b0;
      end
   end

   // State, address and song_done registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         song_done <= 1'b0;
      end else begin
         state     <= state_d;
         addr      <= addr_d;
         song_done <= song_done_d;
      end
   end

   // Entry latch and tempo-unit timer; frozen while paused.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         note_q     <= '0;
         units_left <= '0;
         done_q     <= 1'b0;
         unit_cnt   <= '0;
      end else if (load) begin
         note_q     <= sheet_note;
         units_left <= sheet_dur;
         done_q     <= sheet_done;
         unit_cnt   <= '0;
      end else if (playing) begin
         if (unit_wrap) begin
            unit_cnt   <= '0;
            units_left <= units_left - DUR_W'(1);
         end else begin
            unit_cnt <= unit_cnt + UNIT_W'(1);
         end
      end
   end

   tone_gen #(
      .NOTE_W (NOTE_W)
   ) u_tone_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (playing),
      .clear (state != ST_PLAY),
      .note  (note_q),
      .tone  (tone_raw)
   );

endmodule
